// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle signed multiply/divide unit behind a start/done handshake.
//   MULT uses radix-2 Booth recoding (one step per cycle), DIV uses
//   restoring division on magnitudes with a sign fix-up on the last step.
//   Results land in HI/LO on the edge that enters FINISH; done follows
//   one cycle later as a registered pulse.
//
// Ports
//   clk      : clock, all state updates on posedge
//   rst      : synchronous reset, active-high
//   start    : request, accepted only in IDLE while done is low
//   op       : 0 = MULT, 1 = DIV (captured with start)
//   a, b     : signed operands (captured with start)
//   busy     : high while a MULT/DIV iteration is in progress
//   done     : one-cycle completion pulse
//   div_zero : high together with done when a DIV had b == 0
//   hi, lo   : MULT upper/lower product, DIV remainder/quotient
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    // Two guard bits on the accumulator keep Booth add/subtract of the
    // most-negative multiplicand from overflowing before the shift.
    localparam int AW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [AW-1:0]    acc_hi_reg;   // Booth accumulator / division remainder
    logic [WIDTH-1:0] acc_lo_reg;   // Booth multiplier / dividend-quotient
    logic             q_m1_reg;     // Booth q[-1]
    logic [WIDTH-1:0] m_reg;        // multiplicand or |divisor|
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic             dz_reg;
    logic             done_reg;
    logic             div_zero_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             launch;
    logic             last_step;
    logic             b_is_zero;

    // start is ignored during the done cycle so a held start only launches
    // once done has dropped.
    assign launch    = (state_reg == IDLE) && start && !done_reg;
    assign last_step = (count_reg == CW'(WIDTH - 1));
    assign b_is_zero = (b == '0);

    // ---------------- Booth step ----------------
    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    booth_sum;
    logic [AW-1:0]    booth_hi;
    logic [WIDTH-1:0] booth_lo;

    assign m_ext = {{2{m_reg[WIDTH-1]}}, m_reg};

    always_comb begin
        booth_sum = acc_hi_reg;
        case ({acc_lo_reg[0], q_m1_reg})
            2'b01:   booth_sum = acc_hi_reg + m_ext;
            2'b10:   booth_sum = acc_hi_reg - m_ext;
            default: booth_sum = acc_hi_reg;
        endcase
    end

    assign booth_hi = {booth_sum[AW-1], booth_sum[AW-1:1]};
    assign booth_lo = {booth_sum[0], acc_lo_reg[WIDTH-1:1]};

    // ---------------- Restoring division step ----------------
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    assign div_shift = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_reg};
    assign q_bit     = ~div_diff[WIDTH];
    assign rem_next  = q_bit ? div_diff : div_shift;
    assign quo_next  = {acc_lo_reg[WIDTH-2:0], q_bit};
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign quo_final = (sign_a_reg ^ sign_b_reg) ? -quo_next : quo_next;
    assign rem_final = sign_a_reg ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    if (op && b_is_zero) begin
                        state_next = FINISH;
                    end else begin
                        state_next = op ? DIV : MULT;
                    end
                end
            end
            MULT, DIV: begin
                if (last_step) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            q_m1_reg     <= 1'b0;
            m_reg        <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            dz_reg       <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            done_reg     <= (state_reg == FINISH);
            div_zero_reg <= (state_reg == FINISH) && dz_reg;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        count_reg  <= '0;
                        acc_hi_reg <= '0;
                        q_m1_reg   <= 1'b0;
                        sign_a_reg <= a[WIDTH-1];
                        sign_b_reg <= b[WIDTH-1];
                        dz_reg     <= op && b_is_zero;
                        if (op) begin
                            acc_lo_reg <= a[WIDTH-1] ? -a : a;
                            m_reg      <= b[WIDTH-1] ? -b : b;
                        end else begin
                            acc_lo_reg <= b;
                            m_reg      <= a;
                        end
                    end
                end
                MULT: begin
                    count_reg  <= count_reg + CW'(1);
                    acc_hi_reg <= booth_hi;
                    acc_lo_reg <= booth_lo;
                    q_m1_reg   <= acc_lo_reg[0];
                    if (last_step) begin
                        hi_reg <= booth_hi[WIDTH-1:0];
                        lo_reg <= booth_lo;
                    end
                end
                DIV: begin
                    count_reg  <= count_reg + CW'(1);
                    acc_hi_reg <= {1'b0, rem_next};
                    acc_lo_reg <= quo_next;
                    if (last_step) begin
                        hi_reg <= rem_final;
                        lo_reg <= quo_final;
                    end
                end
                default: begin
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign busy     = (state_reg == MULT) || (state_reg == DIV);
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed-vector bench for mult_div_unit (WIDTH = 32). Each operation is
//   launched with a one-cycle start, then latency, busy length, div_zero and
//   HI/LO are compared against hand-computed values.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and wait for done. edges = number of posedges
    // after the start edge at which done was first seen; busy_cnt = cycles
    // with busy high. Start is re-pulsed for edges in [pulse_lo, pulse_hi].
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input int pulse_lo, input int pulse_hi,
                          output int edges, output int busy_cnt, output logic dz,
                          output int overlap);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        edges = 0; busy_cnt = 0; overlap = 0;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; op = $urandom_range(0, 1);
        while (!done && edges < 100) begin
            if (busy) busy_cnt++;
            if (div_zero) overlap++;
            start = (edges >= pulse_lo && edges <= pulse_hi);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        dz = div_zero;
        if (busy && done) overlap++;
        $display("op=%0d a=0x%08h b=0x%08h edges=%0d busy=%0d dz=%0d hi=0x%08h lo=0x%08h",
                 o, x, y, edges, busy_cnt, dz, hi, lo);
    endtask

    int   edges;
    int   busy_cnt;
    int   overlap;
    int   cnt;
    logic dz;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // 1. MULT 7 * -3
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1, edges, busy_cnt, dz, overlap);
        check("mul1_latency", 64'(edges), 64'd33);
        check("mul1_busy", 64'(busy_cnt), 64'd32);
        check("mul1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul1_overlap", 64'(overlap), 64'd0);

        // 2. MULT most-negative squared
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1, edges, busy_cnt, dz, overlap);
        check("mul2_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
        check("mul2_dz", {63'd0, dz}, 64'd0);

        // 3. DIV sign cases
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, edges, busy_cnt, dz, overlap);
        check("div1_latency", 64'(edges), 64'd33);
        check("div1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1, edges, busy_cnt, dz, overlap);
        check("div2_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        run_op(1'b1, 32'd100, 32'd7, -1, -1, edges, busy_cnt, dz, overlap);
        check("div3_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        // 4. Preload via MULT, then divide by zero
        run_op(1'b0, 32'h1234_5678, 32'h0000_0100, -1, -1, edges, busy_cnt, dz, overlap);
        check("mul3_hilo", {hi, lo}, 64'h0000_0012_3456_7800);
        run_op(1'b1, 32'd5, 32'd0, -1, -1, edges, busy_cnt, dz, overlap);
        check("dz_latency", 64'(edges), 64'd1);
        check("dz_flag", {63'd0, dz}, 64'd1);
        check("dz_busy", 64'(busy_cnt), 64'd0);
        check("dz_hilo_kept", {hi, lo}, 64'h0000_0012_3456_7800);
        @(negedge clk);
        check("dz_flag_drop", {62'd0, div_zero, done}, 64'd0);

        // 5. Overflow divide, extra starts while busy
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, 6, edges, busy_cnt, dz, overlap);
        check("div_ovf_latency", 64'(edges), 64'd33);
        check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_dz", {63'd0, dz}, 64'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("no_second_op", 64'(cnt), 64'd0);

        // 6. Reset mid-MULT
        @(negedge clk);
        op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("rst_no_done", 64'(cnt), 64'd0);
        $display("reset mid-MULT: busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1, edges, busy_cnt, dz, overlap);
        check("post_rst_latency", 64'(edges), 64'd33);
        check("post_rst_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
